// File: rtl/stack_wb_arb.sv
// ============================================================================
// Module      : stack_wb_arb
// Description : Write-back arbiter for the data/return stack tops and pointers,
//               merging pipeline writes, debug writes and fault detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_wb_arb #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_dsk_wen,
    input  logic        wb_rsk_wen,
    input  logic [15:0] wb_dsk_data,
    input  logic [15:0] wb_rsk_data,
    input  logic [7:0]  wb_dsp_n,
    input  logic [7:0]  wb_rsp_n,
    input  logic        dbg_valid,
    input  logic        dbg_sel,
    input  logic [15:0] dbg_data,
    input  logic        clr_fault,
    output logic        dbg_ready,
    output logic [15:0] T,
    output logic [15:0] R,
    output logic [7:0]  dsp,
    output logic [7:0]  rsp,
    output logic        ds_ovf,
    output logic        ds_unf,
    output logic        rs_ovf,
    output logic        rs_unf,
    output logic        fault
);

    localparam logic [8:0] C_DEPTH = 9'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DBG_ACK = 2'd1,
        S_FAULT   = 2'd2
    } state_t;

    state_t r_state;

    logic w_ds_unf;
    logic w_ds_ovf;
    logic w_rs_unf;
    logic w_rs_ovf;
    logic w_any_fault;
    logic w_dbg_go;

    // Underflow takes precedence: a wrap from 0 to FF is never reported as overflow.
    assign w_ds_unf    = wb_dsk_wen && (dsp == 8'd0) && (wb_dsp_n == 8'hFF);
    assign w_ds_ovf    = wb_dsk_wen && !w_ds_unf && ({1'b0, wb_dsp_n} >= C_DEPTH);
    assign w_rs_unf    = wb_rsk_wen && (rsp == 8'd0) && (wb_rsp_n == 8'hFF);
    assign w_rs_ovf    = wb_rsk_wen && !w_rs_unf && ({1'b0, wb_rsp_n} >= C_DEPTH);
    assign w_any_fault = w_ds_unf | w_ds_ovf | w_rs_unf | w_rs_ovf;

    // Debug yields to a same-cycle pipeline write of the stack it targets.
    assign w_dbg_go = (r_state == S_IDLE) && dbg_valid && !w_any_fault &&
                      (dbg_sel ? !wb_rsk_wen : !wb_dsk_wen);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            T         <= 16'd0;
            R         <= 16'd0;
            dsp       <= 8'd0;
            rsp       <= 8'd0;
            ds_ovf    <= 1'b0;
            ds_unf    <= 1'b0;
            rs_ovf    <= 1'b0;
            rs_unf    <= 1'b0;
            fault     <= 1'b0;
            dbg_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DBG_ACK: begin
                    dbg_ready <= 1'b0;
                    if (w_any_fault) begin
                        ds_ovf  <= ds_ovf | w_ds_ovf;
                        ds_unf  <= ds_unf | w_ds_unf;
                        rs_ovf  <= rs_ovf | w_rs_ovf;
                        rs_unf  <= rs_unf | w_rs_unf;
                        fault   <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        if (wb_dsk_wen) begin
                            T   <= wb_dsk_data;
                            dsp <= wb_dsp_n;
                        end
                        if (wb_rsk_wen) begin
                            R   <= wb_rsk_data;
                            rsp <= wb_rsp_n;
                        end
                        if (w_dbg_go) begin
                            if (dbg_sel) begin
                                R <= dbg_data;
                            end else begin
                                T <= dbg_data;
                            end
                            dbg_ready <= 1'b1;
                            r_state   <= S_DBG_ACK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FAULT: begin
                    dbg_ready <= 1'b0;
                    if (clr_fault) begin
                        ds_ovf  <= 1'b0;
                        ds_unf  <= 1'b0;
                        rs_ovf  <= 1'b0;
                        rs_unf  <= 1'b0;
                        fault   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    dbg_ready <= 1'b0;
                    fault     <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_wb_arb.sv
// ============================================================================
// Module      : tb_stack_wb_arb
// Description : Directed and randomized checks of stack_wb_arb against a
//               behavioural model of the stack write-back rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_wb_arb;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_dsk_wen, wb_rsk_wen;
    logic [15:0] wb_dsk_data, wb_rsk_data;
    logic [7:0]  wb_dsp_n, wb_rsp_n;
    logic        dbg_valid, dbg_sel;
    logic [15:0] dbg_data;
    logic        clr_fault;
    logic        dbg_ready;
    logic [15:0] T, R;
    logic [7:0]  dsp, rsp;
    logic        ds_ovf, ds_unf, rs_ovf, rs_unf, fault;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 = idle, 1 = acknowledging debug, 2 = faulted
    logic [15:0] m_t, m_r;
    logic [7:0]  m_dsp, m_rsp;
    logic        m_dso, m_dsu, m_rso, m_rsu;
    int          m_mode;

    stack_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_dsk_wen(wb_dsk_wen), .wb_rsk_wen(wb_rsk_wen),
        .wb_dsk_data(wb_dsk_data), .wb_rsk_data(wb_rsk_data),
        .wb_dsp_n(wb_dsp_n), .wb_rsp_n(wb_rsp_n),
        .dbg_valid(dbg_valid), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .clr_fault(clr_fault), .dbg_ready(dbg_ready),
        .T(T), .R(R), .dsp(dsp), .rsp(rsp),
        .ds_ovf(ds_ovf), .ds_unf(ds_unf), .rs_ovf(rs_ovf), .rs_unf(rs_unf),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; wb_dsk_wen = 0; wb_rsk_wen = 0;
        wb_dsk_data = 0; wb_rsk_data = 0; wb_dsp_n = 0; wb_rsp_n = 0;
        dbg_valid = 0; dbg_sel = 0; dbg_data = 0; clr_fault = 0;
    endtask

    task automatic model_edge();
        logic du, dov, ru, rov, blocked;
        if (rst) begin
            m_t = 0; m_r = 0; m_dsp = 0; m_rsp = 0;
            m_dso = 0; m_dsu = 0; m_rso = 0; m_rsu = 0; m_mode = 0;
        end else if (m_mode == 2) begin
            if (clr_fault) begin
                m_dso = 0; m_dsu = 0; m_rso = 0; m_rsu = 0; m_mode = 0;
            end
        end else begin
            du  = wb_dsk_wen && m_dsp == 8'd0 && wb_dsp_n == 8'hFF;
            dov = wb_dsk_wen && !du && int'(wb_dsp_n) >= DEPTH;
            ru  = wb_rsk_wen && m_rsp == 8'd0 && wb_rsp_n == 8'hFF;
            rov = wb_rsk_wen && !ru && int'(wb_rsp_n) >= DEPTH;
            if (du || dov || ru || rov) begin
                m_dsu |= du; m_dso |= dov; m_rsu |= ru; m_rso |= rov;
                m_mode = 2;
            end else begin
                if (wb_dsk_wen) begin m_t = wb_dsk_data; m_dsp = wb_dsp_n; end
                if (wb_rsk_wen) begin m_r = wb_rsk_data; m_rsp = wb_rsp_n; end
                blocked = dbg_sel ? wb_rsk_wen : wb_dsk_wen;
                if (m_mode == 0 && dbg_valid && !blocked) begin
                    if (dbg_sel) m_r = dbg_data; else m_t = dbg_data;
                    m_mode = 1;
                end else begin
                    m_mode = 0;
                end
            end
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("T", T, m_t);
        chk("R", R, m_r);
        chk("dsp", 16'(dsp), 16'(m_dsp));
        chk("rsp", 16'(rsp), 16'(m_rsp));
        chk("flags", {12'd0, ds_ovf, ds_unf, rs_ovf, rs_unf}, {12'd0, m_dso, m_dsu, m_rso, m_rsu});
        chk("fault", 16'(fault), 16'(m_mode == 2));
        chk("dbg_ready", 16'(dbg_ready), 16'(m_mode == 1));
    endtask

    initial begin
        idle_inputs();
        m_t = 16'hxxxx; m_r = 16'hxxxx; m_mode = 0;

        // Reset
        rst = 1; tick();
        chk("rst_T", T, 16'h0000);
        chk("rst_fault", 16'(fault), 16'h0);
        idle_inputs();

        // Plain data-stack write
        wb_dsk_wen = 1; wb_dsk_data = 16'h1234; wb_dsp_n = 8'd1; tick();
        chk("wr_T", T, 16'h1234);
        chk("wr_dsp", 16'(dsp), 16'h0001);
        chk("wr_R_hold", R, 16'h0000);
        idle_inputs();

        // Debug conflicting with pipeline write to the same stack
        wb_dsk_wen = 1; wb_dsk_data = 16'h0005; wb_dsp_n = 8'd2;
        dbg_valid = 1; dbg_sel = 0; dbg_data = 16'hBEEF; tick();
        chk("conf_T", T, 16'h0005);
        chk("conf_rdy", 16'(dbg_ready), 16'h0);
        wb_dsk_wen = 0; tick();
        chk("dbg_T", T, 16'hBEEF);
        chk("dbg_rdy", 16'(dbg_ready), 16'h1);
        dbg_valid = 0; tick();
        chk("dbg_rdy_pulse", 16'(dbg_ready), 16'h0);

        // Debug to R alongside a pipeline write to the data stack
        wb_dsk_wen = 1; wb_dsk_data = 16'h0A0A; wb_dsp_n = 8'd0;
        dbg_valid = 1; dbg_sel = 1; dbg_data = 16'h5151; tick();
        chk("par_T", T, 16'h0A0A);
        chk("par_R", R, 16'h5151);
        idle_inputs(); tick();

        // Underflow on the data stack, then an ignored write, then clear
        wb_dsk_wen = 1; wb_dsk_data = 16'h7777; wb_dsp_n = 8'hFF; tick();
        chk("unf_flag", 16'(ds_unf), 16'h1);
        chk("unf_T", T, 16'h0A0A);
        chk("unf_dsp", 16'(dsp), 16'h0000);
        wb_dsk_data = 16'h9999; wb_dsp_n = 8'd3; dbg_valid = 1; tick();
        chk("flt_ign_T", T, 16'h0A0A);
        chk("flt_rdy", 16'(dbg_ready), 16'h0);
        idle_inputs(); clr_fault = 1; tick();
        chk("clr_unf", 16'(ds_unf), 16'h0);
        idle_inputs();

        // Return-stack overflow at the boundary, suppressing the data write
        wb_rsk_wen = 1; wb_rsp_n = 8'(DEPTH); wb_rsk_data = 16'h2222;
        wb_dsk_wen = 1; wb_dsp_n = 8'd2; wb_dsk_data = 16'h1111; tick();
        chk("ovf_flag", 16'(rs_ovf), 16'h1);
        chk("ovf_T", T, 16'h0A0A);
        idle_inputs(); clr_fault = 1; tick();
        chk("clr_fault", 16'(fault), 16'h0);
        idle_inputs();

        // Largest legal pointer is accepted
        wb_rsk_wen = 1; wb_rsp_n = 8'(DEPTH - 1); wb_rsk_data = 16'h3333; tick();
        chk("edge_rsp", 16'(rsp), 16'(DEPTH - 1));
        idle_inputs();

        // Reset during DBG_ACK
        dbg_valid = 1; dbg_sel = 1; dbg_data = 16'hCAFE; tick();
        chk("ack_R", R, 16'hCAFE);
        idle_inputs(); rst = 1; tick();
        chk("rst_ack_rdy", 16'(dbg_ready), 16'h0);
        chk("rst_ack_R", R, 16'h0000);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 79) == 0);
            wb_dsk_wen  = $urandom_range(0, 2) == 0;
            wb_rsk_wen  = $urandom_range(0, 2) == 0;
            wb_dsk_data = 16'($urandom);
            wb_rsk_data = 16'($urandom);
            wb_dsp_n    = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, DEPTH + 3));
            wb_rsp_n    = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, DEPTH + 3));
            dbg_valid   = $urandom_range(0, 1) == 1;
            dbg_sel     = $urandom_range(0, 1) == 1;
            dbg_data    = 16'($urandom);
            clr_fault   = $urandom_range(0, 5) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
